// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM encoding and bus-level constants.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_WR_BYTE,
        ST_WR_ACK, ST_RD_BYTE, ST_RD_ACK, ST_IGNORE
    } i2c_state_t;

    localparam logic       I2C_ACK       = 1'b0;
    localparam logic       I2C_NACK      = 1'b1;
    localparam int         RW_BIT        = 0;
    localparam logic [7:0] UNDERRUN_BYTE = 8'hFF;

    // Byte presented on the bus when the upload source has nothing ready.
    function automatic logic [7:0] tx_pick(input logic valid, input logic [7:0] data);
        return valid ? data : UNDERRUN_BYTE;
    endfunction

endpackage

// File: rtl/i2c_if.sv
// User-side byte streams and status of the I2C target.
interface i2c_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_first;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       evt_stop;
    logic       evt_underrun;

    modport slave (output rx_data, rx_valid, rx_first, tx_ready, busy, evt_stop, evt_underrun,
                   input  tx_data, tx_valid);
    modport master(input  rx_data, rx_valid, rx_first, tx_ready, busy, evt_stop, evt_underrun,
                   output tx_data, tx_valid);
endinterface

// File: rtl/i2c_glitch_filter.sv
// 2-FF synchronizer, run-length glitch filter and edge detect for one bus line.
module i2c_glitch_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [1:0] sync;
    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= 2'b11;
            cnt   <= '0;
            level <= 1'b1;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], din};
            rise <= 1'b0;
            fall <= 1'b0;
            // The level only follows after FILTER_LEN consecutive differing samples.
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == 4'(FILTER_LEN - 1)) begin
                level <= sync[1];
                cnt   <= '0;
                rise  <= sync[1];
                fall  <= ~sync[1];
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end
endmodule

// File: rtl/i2c_target.sv
// Oversampled I2C target: answers own_addr, streams written bytes out, uploads bytes on reads.
module i2c_target
    import i2c_pkg::*;
#(
    parameter int FILTER_LEN       = 3,
    parameter bit NACK_ON_UNDERRUN = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] own_addr,
    input  logic       i2c_scl,
    inout  wire        i2c_sda,
    i2c_if.slave       usr
);
    if (NACK_ON_UNDERRUN != 1'b0) begin : g_bad_cfg
        $error("NACK_ON_UNDERRUN is reserved and must be 0");
    end

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_flt (
        .clk(clk), .rst(rst), .din(i2c_scl), .level(scl_lvl), .rise(scl_rise), .fall(scl_fall));
    i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_flt (
        .clk(clk), .rst(rst), .din(i2c_sda), .level(sda_lvl), .rise(sda_rise), .fall(sda_fall));

    i2c_state_t state;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic [6:0] addr_q;
    logic       rw, first, sda_oe;
    logic       start_det, stop_det;
    logic [7:0] tx_byte;

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;
    assign tx_byte   = tx_pick(usr.tx_valid, usr.tx_data);
    // rst gates the driver directly so the bus is freed in the cycle reset is seen.
    assign i2c_sda   = (sda_oe && !rst) ? 1'b0 : 1'bz;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            bit_cnt          <= '0;
            shreg            <= '0;
            addr_q           <= '0;
            rw               <= 1'b0;
            first            <= 1'b0;
            sda_oe           <= 1'b0;
            usr.rx_data      <= 8'h00;
            usr.rx_valid     <= 1'b0;
            usr.rx_first     <= 1'b0;
            usr.tx_ready     <= 1'b0;
            usr.busy         <= 1'b0;
            usr.evt_stop     <= 1'b0;
            usr.evt_underrun <= 1'b0;
        end else begin
            usr.rx_valid     <= 1'b0;
            usr.tx_ready     <= 1'b0;
            usr.evt_stop     <= 1'b0;
            usr.evt_underrun <= 1'b0;
            if (start_det) begin
                state    <= ST_ADDR;
                bit_cnt  <= '0;
                sda_oe   <= 1'b0;
                usr.busy <= 1'b0;
                addr_q   <= own_addr;
            end else if (stop_det) begin
                state        <= ST_IDLE;
                sda_oe       <= 1'b0;
                usr.evt_stop <= usr.busy;
                usr.busy     <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR: if (scl_rise) begin
                        shreg   <= {shreg[6:0], sda_lvl};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (shreg[6:0] == addr_q) begin
                                state    <= ST_ADDR_ACK;
                                rw       <= sda_lvl;
                                usr.busy <= 1'b1;
                                first    <= 1'b1;
                            end else begin
                                state <= ST_IGNORE;
                            end
                        end
                    end
                    // sda_oe doubles as the phase flag inside both ACK slots.
                    ST_ADDR_ACK: if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe <= 1'b1;
                        end else begin
                            bit_cnt <= '0;
                            if (rw) begin
                                sda_oe           <= ~tx_byte[7];
                                shreg            <= {tx_byte[6:0], 1'b1};
                                usr.tx_ready     <= usr.tx_valid;
                                usr.evt_underrun <= ~usr.tx_valid;
                                state            <= ST_RD_BYTE;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= ST_WR_BYTE;
                            end
                        end
                    end
                    ST_WR_BYTE: if (scl_rise) begin
                        shreg   <= {shreg[6:0], sda_lvl};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= ST_WR_ACK;
                    end
                    ST_WR_ACK: if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe       <= 1'b1;
                            usr.rx_data  <= shreg;
                            usr.rx_valid <= 1'b1;
                            usr.rx_first <= first;
                            first        <= 1'b0;
                        end else begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= '0;
                            state   <= ST_WR_BYTE;
                        end
                    end
                    ST_RD_BYTE: if (scl_fall) begin
                        if (bit_cnt == 3'd7) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= '0;
                            state   <= ST_RD_ACK;
                        end else begin
                            sda_oe  <= ~shreg[7];
                            shreg   <= {shreg[6:0], 1'b1};
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    ST_RD_ACK: begin
                        if (scl_rise && sda_lvl == I2C_NACK) begin
                            state    <= ST_IGNORE;
                            usr.busy <= 1'b0;
                        end else if (scl_fall) begin
                            sda_oe           <= ~tx_byte[7];
                            shreg            <= {tx_byte[6:0], 1'b1};
                            usr.tx_ready     <= usr.tx_valid;
                            usr.evt_underrun <= ~usr.tx_valid;
                            bit_cnt          <= '0;
                            state            <= ST_RD_BYTE;
                        end
                    end
                    default: sda_oe <= 1'b0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged initiator plus a transaction-level expectation model.
module tb_i2c_target;
    localparam int H = 30;

    typedef struct packed { logic [7:0] d; logic f; } rx_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] own_addr = 7'h50;
    logic       scl = 1'b1;
    logic       sda_low = 1'b0;
    wire        sda;

    pullup (sda);
    assign sda = sda_low ? 1'b0 : 1'bz;

    i2c_if bus();

    i2c_target #(.FILTER_LEN(3), .NACK_ON_UNDERRUN(1'b0)) dut (
        .clk(clk), .rst(rst), .own_addr(own_addr), .i2c_scl(scl), .i2c_sda(sda), .usr(bus));

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int n_rx = 0, n_ready = 0, n_under = 0, n_stop = 0;
    int exp_stop = 0, exp_ready = 0, exp_under = 0;
    rx_t exp_rx[$];
    rx_t mon_e;
    logic [7:0] txq[$];
    logic [7:0] last_rx = 8'h00;
    logic addressed = 1'b0, first_pending = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Every cycle: match output pulses against the expectation queues; also acts as the tx source.
    initial begin
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.rx_valid) begin
                    n_rx++;
                    last_rx = bus.rx_data;
                    chk("rx_expected_pending", 32'(exp_rx.size() != 0), 1);
                    if (exp_rx.size() != 0) begin
                        mon_e = exp_rx.pop_front();
                        chk("rx_data", bus.rx_data, mon_e.d);
                        chk("rx_first", bus.rx_first, mon_e.f);
                    end
                end
                if (bus.tx_ready) begin
                    n_ready++;
                    chk("tx_ready_with_valid", bus.tx_valid, 1);
                    if (txq.size() != 0) void'(txq.pop_front());
                end
                if (bus.evt_underrun) begin
                    n_under++;
                    chk("underrun_when_empty", bus.tx_valid, 0);
                end
                if (bus.evt_stop) n_stop++;
            end
            bus.tx_valid = (txq.size() != 0);
            bus.tx_data  = (txq.size() != 0) ? txq[0] : 8'h00;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // One SCL period; entered right after SCL falls, leaves right after the next fall.
    task automatic bit_xfer(input logic b, input logic glitch, output logic r);
        wclk(4);
        @(negedge clk);
        chk("busy", bus.busy, addressed);
        sda_low = !b;
        wclk(H - 5);
        scl = 1'b1;
        if (glitch) begin
            wclk(7); sda_low = !sda_low; wclk(1); sda_low = !sda_low; wclk(7);
        end else begin
            wclk(15);
        end
        @(negedge clk);
        r = sda;
        wclk(H / 2);
        scl = 1'b0;
    endtask

    task automatic send_start();
        wclk(10); sda_low = 1'b0;
        wclk(H);  scl = 1'b1;
        wclk(H);  sda_low = 1'b1;
        wclk(H);  scl = 1'b0;
        addressed = 1'b0;
        first_pending = 1'b0;
    endtask

    task automatic send_stop();
        wclk(10); sda_low = 1'b1;
        wclk(H);  scl = 1'b1;
        wclk(H);  sda_low = 1'b0;
        wclk(H);
        if (addressed) exp_stop++;
        addressed = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic g, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], g, r);
        bit_xfer(1'b1, 1'b0, ack);
    endtask

    task automatic send_addr(input logic [7:0] a);
        logic r, ack;
        for (int i = 7; i >= 0; i--) bit_xfer(a[i], 1'b0, r);
        addressed = (a[7:1] == own_addr);
        first_pending = addressed && !a[0];
        bit_xfer(1'b1, 1'b0, ack);
        chk("addr_ack", ack, addressed ? 1'b0 : 1'b1);
    endtask

    task automatic write_byte(input logic [7:0] d, input logic g);
        logic ack;
        exp_rx.push_back('{d: d, f: first_pending});
        first_pending = 1'b0;
        send_byte(d, g, ack);
        chk("wr_ack", ack, 0);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] d);
        logic r;
        logic [7:0] exp_b;
        exp_b = (txq.size() != 0) ? txq[0] : 8'hFF;
        if (txq.size() != 0) exp_ready++; else exp_under++;
        for (int i = 7; i >= 0; i--) bit_xfer(1'b1, 1'b0, d[i]);
        bit_xfer(nack, 1'b0, r);
        if (nack) addressed = 1'b0;
        chk("rd_byte", d, exp_b);
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_evt_stop"}, n_stop, exp_stop);
        chk({tag, "_tx_ready"}, n_ready, exp_ready);
        chk({tag, "_underrun"}, n_under, exp_under);
    endtask

    initial begin
        logic [7:0] d;
        logic ack, r;

        // reset state
        wclk(5);
        @(negedge clk);
        chk("rst_rx_data", bus.rx_data, 8'h00);
        chk("rst_rx_valid", bus.rx_valid, 0);
        chk("rst_rx_first", bus.rx_first, 0);
        chk("rst_tx_ready", bus.tx_ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_evt_stop", bus.evt_stop, 0);
        chk("rst_evt_underrun", bus.evt_underrun, 0);
        chk("rst_sda", sda, 1);
        rst = 1'b0;
        wclk(20);

        // write A0, A5, 3C, STOP
        send_start();
        send_addr(8'hA0);
        write_byte(8'hA5, 1'b0);
        write_byte(8'h3C, 1'b0);
        send_stop();
        chk("t1_rx_count", n_rx, 2);
        chk("t1_last_rx", last_rx, 8'h3C);
        chk("t1_stop_count", n_stop, 1);
        check_counts("t1");

        // foreign address: NACKed, frame ignored
        send_start();
        send_addr(8'hA2);
        send_byte(8'h55, 1'b0, ack);
        chk("ign_data_nack", ack, 1);
        send_stop();
        chk("t2_rx_count", n_rx, 2);
        check_counts("t2");

        // read two bytes, ACK then NACK
        txq.push_back(8'h11);
        txq.push_back(8'h22);
        wclk(2);
        send_start();
        send_addr(8'hA1);
        recv_byte(1'b0, d);
        chk("t3_byte0", d, 8'h11);
        recv_byte(1'b1, d);
        chk("t3_byte1", d, 8'h22);
        wclk(20);
        @(negedge clk);
        chk("t3_sda_released", sda, 1);
        send_stop();
        chk("t3_ready_count", n_ready, 2);
        check_counts("t3");

        // read with empty source: underrun
        send_start();
        send_addr(8'hA1);
        recv_byte(1'b1, d);
        chk("t4_byte_ff", d, 8'hFF);
        send_stop();
        chk("t4_underrun_count", n_under, 1);
        chk("t4_ready_count", n_ready, 2);
        check_counts("t4");

        // write, repeated START, read one byte
        txq.push_back(8'h77);
        send_start();
        send_addr(8'hA0);
        write_byte(8'h12, 1'b0);
        send_start();
        chk("t5_no_stop_on_rs", n_stop, 1);
        send_addr(8'hA1);
        recv_byte(1'b1, d);
        chk("t5_read_byte", d, 8'h77);
        send_stop();
        chk("t5_last_rx", last_rx, 8'h12);
        check_counts("t5");

        // 1-clk SDA glitches while SCL high on every data bit
        send_start();
        send_addr(8'hA0);
        write_byte(8'hC3, 1'b1);
        send_stop();
        chk("t6_last_rx", last_rx, 8'hC3);
        check_counts("t6");

        // reset in the middle of a read byte of zeros
        txq.push_back(8'h00);
        wclk(2);
        send_start();
        send_addr(8'hA1);
        exp_ready++;
        for (int i = 0; i < 3; i++) begin
            bit_xfer(1'b1, 1'b0, r);
            chk("t7_rd_bit", r, 0);
        end
        wclk(15);
        @(negedge clk);
        chk("t7_sda_driven", sda, 0);
        @(posedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t7_sda_rel_same_cycle", sda, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t7_rx_valid", bus.rx_valid, 0);
            chk("t7_tx_ready", bus.tx_ready, 0);
            chk("t7_busy", bus.busy, 0);
            chk("t7_rx_data", bus.rx_data, 8'h00);
            chk("t7_rx_first", bus.rx_first, 0);
            chk("t7_evt_stop", bus.evt_stop, 0);
            chk("t7_evt_underrun", bus.evt_underrun, 0);
            chk("t7_sda", sda, 1);
        end
        @(posedge clk);
        rst = 1'b0;
        addressed = 1'b0;
        first_pending = 1'b0;
        wclk(20);
        send_stop();
        check_counts("t7");
        chk("rx_queue_drained", exp_rx.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
